axi_slave_mem: RTL and testbench

Parametrised AXI4 slave memory, the successor to axi_slave_simple. It provides a DEPTH-word register file behind a full AXI4 burst interface. It supports FIXED, INCR and WRAP bursts, applies WSTRB byte enables, and returns SLVERR for out-of-range or illegal transfers. Read and write channels run independent FSMs, and it sits as a leaf slave behind the interconnect.

---
 rtl/axi_slave_mem.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by a DEPTH-word register file.
// Supports FIXED, INCR and WRAP bursts with WSTRB byte enables. Transfers
// that are out of range or illegal get SLVERR. The read and write channels
// run as independent FSMs.
//
// Ports:
//   ACLK, ARESET            clock; synchronous active-high reset
//   AW*  (ID/ADDR/LEN/SIZE/BURST/VALID/READY)   write address channel
//   W*   (DATA/STRB/LAST/VALID/READY)           write data channel
//   B*   (ID/RESP/VALID/READY)                  write response channel
//   AR*  (ID/ADDR/LEN/SIZE/BURST/VALID/READY)   read address channel
//   R*   (ID/DATA/RESP/LAST/VALID/READY)        read data channel
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SZ     = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic legal(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size == 3'(SZ)) && (burst != 2'b11) && ((burst != 2'b10) || wrap_ok);
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> SZ) < ADDR_WIDTH'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> SZ);
    endfunction

    // WRAP keeps the bits above the (len+1)*bytes window and increments only inside it.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step, mask, res;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   res = addr;
            2'b10:   res = (addr & ~mask) | ((addr + step) & mask);
            default: res = addr + step;
        endcase
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write channel ----------------
    logic [1:0]            w_state;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic [7:0]            w_cnt;
    logic                  w_err;
    logic                  w_legal;
    logic                  w_hs, w_cnt_hit, w_beat_ok, w_done, w_err_next, mem_we;

    always_comb begin
        w_hs       = (w_state == W_DATA) && WVALID && WREADY;
        w_cnt_hit  = (w_cnt == aw_len);
        w_beat_ok  = in_range(aw_addr);
        w_done     = WLAST || w_cnt_hit;
        // A WLAST that disagrees with the beat count (early or missing) is an error.
        w_err_next = w_err || !w_beat_ok || (WLAST != w_cnt_hit);
        mem_we     = w_hs && w_legal && w_beat_ok && !ARESET;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= OKAY;
            BID     <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_legal <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        BID      <= AWID;
                        aw_addr  <= AWADDR;
                        aw_len   <= AWLEN;
                        aw_size  <= AWSIZE;
                        aw_burst <= AWBURST;
                        w_cnt    <= '0;
                        w_legal  <= legal(AWSIZE, AWBURST, AWLEN);
                        w_err    <= !legal(AWSIZE, AWBURST, AWLEN);
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
                        w_cnt   <= w_cnt + 8'd1;
                        w_err   <= w_err_next;
                        if (w_done) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= w_err_next ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[word_idx(aw_addr)][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic [7:0]            r_cnt;
    logic                  r_legal;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ok;

    // Address of the beat loaded at the next edge: the AR address while idle,
    // otherwise the successor of the beat currently presented.
    always_comb begin
        if (r_state == R_IDLE) begin
            rd_addr = ARADDR;
            rd_ok   = legal(ARSIZE, ARBURST, ARLEN) && in_range(ARADDR);
        end else begin
            rd_addr = next_addr(r_addr, ar_len, ar_size, ar_burst);
            rd_ok   = r_legal && in_range(rd_addr);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RRESP   <= OKAY;
            RDATA   <= '0;
            r_cnt   <= '0;
            r_legal <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        RID      <= ARID;
                        r_addr   <= ARADDR;
                        ar_len   <= ARLEN;
                        ar_size  <= ARSIZE;
                        ar_burst <= ARBURST;
                        r_legal  <= legal(ARSIZE, ARBURST, ARLEN);
                        r_cnt    <= '0;
                        RDATA    <= rd_ok ? mem[word_idx(rd_addr)] : '0;
                        RRESP    <= rd_ok ? OKAY : SLVERR;
                        RLAST    <= (ARLEN == 8'd0);
                        RVALID   <= 1'b1;
                        ARREADY  <= 1'b0;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= rd_addr;
                            r_cnt  <= r_cnt + 8'd1;
                            RDATA  <= rd_ok ? mem[word_idx(rd_addr)] : '0;
                            RRESP  <= rd_ok ? OKAY : SLVERR;
                            RLAST  <= (r_cnt + 8'd1 == ar_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: scoreboard bench for axi_slave_mem (32-bit data, 64 words).
// Stimulus tasks update a word-array model and queue the expected B and R
// responses; a monitor compares whatever the DUT presents against the queues.
module tb_axi_slave_mem;
    localparam int DEPTH = 64;
    localparam int IW    = $clog2(DEPTH);

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int          rready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_true(input string name, input bit ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: condition not met (got 0, expected 1)", name);
        end
    endtask

    // Reference address rules, written as plain arithmetic on byte addresses.
    function automatic int unsigned beat_addr(input int unsigned start, input int unsigned len,
                                              input int unsigned burst, input int unsigned i);
        int unsigned win, base;
        if (burst == 0) return start;
        if (burst == 2) begin
            win  = (len + 1) * 4;
            base = start - (start % win);
            return base + ((start - base) + i * 4) % win;
        end
        return start + i * 4;
    endfunction

    function automatic bit is_legal(input int unsigned size, input int unsigned burst,
                                    input int unsigned len);
        if (size != 2 || burst == 3) return 1'b0;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic write_burst(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                               input int unsigned size, input int unsigned burst,
                               input int unsigned wlast_at);
        logic [31:0] d[$];
        logic [3:0]  s[$];
        int unsigned nbeats, a;
        bit          err, leg;
        int          n;
        nbeats = ((wlast_at < len) ? wlast_at : len) + 1;
        leg    = is_legal(size, burst, len);
        err    = !leg || (wlast_at != len);
        for (int unsigned i = 0; i < nbeats; i++) begin
            d.push_back((wd_q.size() != 0) ? wd_q.pop_front() : $urandom);
            s.push_back((ws_q.size() != 0) ? ws_q.pop_front() : 4'hF);
            a = beat_addr(addr, len, burst, i);
            if (a / 4 >= DEPTH) err = 1'b1;
            else if (leg)
                for (int b = 0; b < 4; b++)
                    if (s[i][b]) ref_mem[IW'(a / 4)][8*b +: 8] = d[i][8*b +: 8];
        end
        wd_q.delete();
        ws_q.delete();
        b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
        AWVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!AWREADY && n < 200);
        expect_true("aw_handshake", AWREADY);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int unsigned i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin WVALID = 1'b0; @(posedge ACLK); #1; end
            WDATA = d[i]; WSTRB = s[i]; WLAST = (i == wlast_at); WVALID = 1'b1;
            n = 0;
            do begin @(negedge ACLK); n++; end while (!WREADY && n < 200);
            expect_true("w_handshake", WREADY);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        while (b_q.size() != 0 && n < 2000) begin @(negedge ACLK); n++; end
        expect_true("b_drain", b_q.size() == 0);
        @(posedge ACLK); #1;
    endtask

    task automatic read_burst(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                              input int unsigned size, input int unsigned burst, input bit wait_done);
        r_exp_t      e;
        int unsigned a;
        bit          leg;
        int          n;
        leg = is_legal(size, burst, len);
        for (int unsigned i = 0; i <= len; i++) begin
            a      = beat_addr(addr, len, burst, i);
            e.id   = id;
            e.last = (i == len);
            if (leg && a / 4 < DEPTH) begin e.data = ref_mem[IW'(a / 4)]; e.resp = 2'b00; end
            else                      begin e.data = 32'h0;               e.resp = 2'b10; end
            r_q.push_back(e);
        end
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
        ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < 200);
        expect_true("ar_handshake", ARREADY);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        if (wait_done) begin
            n = 0;
            while (r_q.size() != 0 && n < 3000) begin @(negedge ACLK); n++; end
            expect_true("r_drain", r_q.size() == 0);
            @(posedge ACLK); #1;
        end
    endtask

    // Ready drivers change just after the rising edge.
    initial begin
        BREADY = 1'b0; RREADY = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            BREADY = ($urandom_range(0, 3) != 0);
            case (rready_mode)
                0:       RREADY = 1'b1;
                1:       RREADY = ~RREADY;
                default: RREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every presented response is checked against the queue head;
    // the head is popped only when the handshake will complete.
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (BVALID) begin
                    if (b_q.size() == 0) begin
                        n_checks++; n_fails++;
                        $display("FAIL b_unexpected: BVALID=1 with BID=%h but no response expected", BID);
                    end else begin
                        check("bid",   32'(BID),   32'(b_q[0].id));
                        check("bresp", 32'(BRESP), 32'(b_q[0].resp));
                        if (BREADY) void'(b_q.pop_front());
                    end
                end
                if (RVALID) begin
                    if (r_q.size() == 0) begin
                        n_checks++; n_fails++;
                        $display("FAIL r_unexpected: RVALID=1 with RDATA=%h but no beat expected", RDATA);
                    end else begin
                        check("rid",   32'(RID),   32'(r_q[0].id));
                        check("rdata", RDATA,      r_q[0].data);
                        check("rresp", 32'(RRESP), 32'(r_q[0].resp));
                        check("rlast", 32'(RLAST), 32'(r_q[0].last));
                        if (RREADY) void'(r_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached with %0d failures so far", n_fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_wready",  32'(WREADY),  32'd0);
        check("rst_bvalid",  32'(BVALID),  32'd0);
        check("rst_rvalid",  32'(RVALID),  32'd0);
        check("rst_rlast",   32'(RLAST),   32'd0);
        check("rst_ids",     32'({BID, RID}), 32'd0);
        check("rst_resps",   32'({BRESP, RRESP}), 32'd0);
        check("rst_rdata",   RDATA, 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); @(negedge ACLK);
        check("awready_after_reset", 32'(AWREADY), 32'd1);
        check("arready_after_reset", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;

        rready_mode = 2;
        // Fill every word so later reads never touch uninitialised storage.
        write_burst(4'h0, 0, DEPTH - 1, 2, 1, DEPTH - 1);
        read_burst(4'h1, 0, DEPTH - 1, 2, 1, 1'b1);

        // Single beat.
        wd_q.push_back(32'h12345678);
        write_burst(4'h1, 0, 0, 2, 1, 0);
        read_burst(4'h2, 0, 0, 2, 1, 1'b1);

        // 4-beat INCR read back with RREADY toggling.
        wd_q = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h87654321};
        write_burst(4'h3, 0, 3, 2, 1, 3);
        rready_mode = 1;
        read_burst(4'h4, 0, 3, 2, 1, 1'b1);
        rready_mode = 2;

        // Byte strobes.
        wd_q.push_back(32'hFFFFFFFF);
        write_burst(4'h5, 32'hC, 0, 2, 1, 0);
        wd_q.push_back(32'h12345678); ws_q.push_back(4'b0011);
        write_burst(4'h6, 32'hC, 0, 2, 1, 0);
        read_burst(4'h7, 32'hC, 0, 2, 1, 1'b1);

        // WRAP read and write.
        wd_q = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        write_burst(4'h8, 0, 3, 2, 1, 3);
        read_burst(4'h9, 32'h8, 3, 2, 2, 1'b1);
        write_burst(4'hA, 32'h14, 7, 2, 2, 7);
        read_burst(4'hB, 0, 15, 2, 1, 1'b1);

        // Burst running off the end of memory.
        write_burst(4'hC, (DEPTH - 1) * 4, 1, 2, 1, 1);
        read_burst(4'hD, (DEPTH - 1) * 4, 1, 2, 1, 1'b1);

        // Illegal transactions leave memory untouched.
        write_burst(4'hE, 32'h10, 0, 2, 3, 0);
        write_burst(4'hF, 32'h10, 0, 1, 1, 0);
        write_burst(4'h1, 32'h10, 2, 2, 2, 2);
        read_burst(4'h2, 32'h10, 0, 2, 3, 1'b1);
        read_burst(4'h3, 32'h10, 1, 1, 1, 1'b1);
        read_burst(4'h4, 32'h10, 2, 2, 2, 1'b1);
        read_burst(4'h5, 32'h10, 3, 2, 1, 1'b1);

        // Early and missing WLAST, FIXED burst, and a 256-beat burst.
        write_burst(4'h6, 32'h20, 3, 2, 1, 1);
        write_burst(4'h7, 32'h40, 2, 2, 1, 9);
        write_burst(4'h8, 32'h60, 3, 2, 0, 3);
        read_burst(4'h9, 32'h20, 15, 2, 1, 1'b1);
        read_burst(4'hA, 32'h60, 2, 2, 0, 1'b1);
        write_burst(4'hB, 0, 255, 2, 1, 255);
        read_burst(4'hC, 0, 255, 2, 1, 1'b1);

        // Randomised mix, including illegal and out-of-range requests.
        for (int k = 0; k < 30; k++) begin
            int unsigned r, sz, bu, ln, ad, wl, pick;
            r  = $urandom_range(0, 9);
            sz = (r == 1) ? $urandom_range(0, 1) : 2;
            bu = (r == 0) ? 3 : $urandom_range(0, 2);
            if (bu == 2) begin
                pick = $urandom_range(0, 4);
                ln   = (pick == 4) ? 2 : (2 << pick) - 1;
            end else begin
                ln = $urandom_range(0, 15);
            end
            ad = $urandom_range(0, DEPTH + 4) * 4;
            wl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ln + 1) : ln;
            for (int unsigned i = 0; i <= ln; i++) ws_q.push_back(4'($urandom));
            write_burst(4'(k), ad, ln, sz, bu, wl);
            read_burst(4'(k + 1), ad, ln, sz, bu, 1'b1);
        end

        // Reset while beat 2 of a 4-beat read is being presented.
        rready_mode = 0;
        read_burst(4'h6, 0, 3, 2, 1, 1'b0);
        n = 0;
        do begin @(negedge ACLK); #1; n++; end while (r_q.size() > 2 && n < 100);
        expect_true("reached_beat2", r_q.size() == 2);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        check("rvalid_after_reset_edge",  32'(RVALID),  32'd0);
        check("rlast_after_reset_edge",   32'(RLAST),   32'd0);
        check("arready_during_reset",     32'(ARREADY), 32'd0);
        r_q.delete();
        ARESET = 1'b0;
        @(posedge ACLK); @(negedge ACLK);
        check("arready_after_release", 32'(ARREADY), 32'd1);
        check("awready_after_release", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        rready_mode = 2;
        read_burst(4'h7, 0, 15, 2, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
